// File: rtl/piso_z_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_z_if
//  Description : Bus bundle for piso_z. It carries the frame input from the PE
//                array and the serial valid/ready output toward the result
//                sink. The slave modport is the piso_z side and the master
//                modport is the producer/sink side.
//  Revision    : 1.0  initial release
// ============================================================================
interface piso_z_if #(
    parameter int DW     = 16,
    parameter int PE_NUM = 4
) ();
    logic                     p_in_v;
    logic [PE_NUM*2*DW-1:0]   p_in;
    logic                     p_in_rdy;
    logic                     s_out_v;
    logic [2*DW-1:0]          s_out;
    logic                     s_out_last;
    logic                     s_out_rdy;

    modport slave (
        input  p_in_v, p_in, s_out_rdy,
        output p_in_rdy, s_out_v, s_out, s_out_last
    );

    modport master (
        output p_in_v, p_in, s_out_rdy,
        input  p_in_rdy, s_out_v, s_out, s_out_last
    );
endinterface
`default_nettype wire

// File: rtl/piso_z.sv
`default_nettype none
// ============================================================================
//  Module      : piso_z
//  Description : Parallel-in/serial-out stage behind the PE array. It captures
//                a whole frame of PE_NUM complex words into one bank of a
//                ping-pong pair and streams the words out one per cycle,
//                lane 0 first, over a valid/ready handshake.
//                Optional feature macro: PISO_OVF_EN enables the sticky
//                overflow flag. When it is undefined, overflow is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_z #(
    parameter int DW     = 16,
    parameter int PE_NUM = 4
) (
    input  wire logic clk,
    input  wire logic rst,       // synchronous, active low
    input  wire logic ce,
    piso_z_if.slave   bus,
    output logic      overflow
);
    localparam int CW       = $clog2(PE_NUM);
    localparam int c_word_w = 2 * DW;

    localparam logic [CW-1:0] c_lane_last = CW'(PE_NUM - 1);

    // Per-bank occupancy state
    localparam logic [0:0] c_bank_empty = 1'b0;
    localparam logic [0:0] c_bank_full  = 1'b1;

    logic [c_word_w-1:0] r_bank [2][PE_NUM];
    logic [0:0]          r_bank_st [2];
    logic                r_wr_sel;
    logic                r_rd_sel;
    logic [CW-1:0]       r_lane;
    logic                r_s_out_v;
    logic [c_word_w-1:0] r_s_out;
    logic                r_s_out_last;

    logic w_p_in_rdy;
    logic w_cap;
    logic w_adv;
    logic w_rd_full;
    logic w_lane_last;

    // Readiness depends only on registered bank state, so the sink's ready
    // never reaches p_in_rdy combinationally.
    assign w_p_in_rdy  = (r_bank_st[r_wr_sel] == c_bank_empty);
    assign w_cap       = ce & bus.p_in_v & w_p_in_rdy;
    assign w_adv       = ~r_s_out_v | bus.s_out_rdy;
    assign w_rd_full   = (r_bank_st[r_rd_sel] == c_bank_full);
    assign w_lane_last = (r_lane == c_lane_last);

    // Frame data banks. The contents need no reset because bank state
    // decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_cap) begin
            for (int i = 0; i < PE_NUM; i++) begin
                r_bank[r_wr_sel][i] <= bus.p_in[i*c_word_w +: c_word_w];
            end
        end
    end

    // Bank state, write/read bank selects, lane counter and output register.
    // The read side is idle when the output register is empty or draining a
    // finished frame. It streams whenever the read bank is full and the
    // output register can advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank_st[0] <= c_bank_empty;
            r_bank_st[1] <= c_bank_empty;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_lane       <= '0;
            r_s_out_v    <= 1'b0;
            r_s_out      <= '0;
            r_s_out_last <= 1'b0;
        end else if (ce) begin
            // A capture always targets the bank that is not being released in
            // the same cycle, because a bank cannot be both empty and full.
            if (w_cap) begin
                r_bank_st[r_wr_sel] <= c_bank_full;
                r_wr_sel            <= ~r_wr_sel;
            end
            if (w_adv) begin
                if (w_rd_full) begin
                    r_s_out_v    <= 1'b1;
                    r_s_out      <= r_bank[r_rd_sel][r_lane];
                    r_s_out_last <= w_lane_last;
                    if (w_lane_last) begin
                        r_bank_st[r_rd_sel] <= c_bank_empty;
                        r_rd_sel            <= ~r_rd_sel;
                        r_lane              <= '0;
                    end else begin
                        r_lane <= r_lane + CW'(1);
                    end
                end else begin
                    // The word was taken and nothing is pending. s_out keeps
                    // its last value.
                    r_s_out_v    <= 1'b0;
                    r_s_out_last <= 1'b0;
                end
            end
        end
    end

    assign bus.p_in_rdy   = w_p_in_rdy;
    assign bus.s_out_v    = r_s_out_v;
    assign bus.s_out      = r_s_out;
    assign bus.s_out_last = r_s_out_last;

`ifdef PISO_OVF_EN
    logic r_overflow;

    // Sticky flag for a frame offered while both banks are occupied
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (ce && bus.p_in_v && !w_p_in_rdy) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_piso_z.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_z
//  Description : Bench for piso_z (PE_NUM=4, DW=16). The reference model is a
//                word queue: captured frames append their lanes in order, and
//                the output register pops one word whenever it may advance.
//                Buffer occupancy is the number of frames that still have
//                words which are not yet loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso_z;
    localparam int DW     = 16;
    localparam int PE_NUM = 4;
    localparam int WW     = 2 * DW;

`ifdef PISO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;
    logic overflow;

    piso_z_if #(.DW(DW), .PE_NUM(PE_NUM)) bus ();

    piso_z #(.DW(DW), .PE_NUM(PE_NUM)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .bus      (bus),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [WW-1:0] mq [$];
    bit            ml [$];
    bit            m_ov   = 1'b0;
    bit            m_last = 1'b0;
    bit            m_ovf  = 1'b0;
    logic [WW-1:0] m_word = '0;

    function automatic bit m_rdy();
        return ((mq.size() + PE_NUM - 1) / PE_NUM) < 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge
    always @(posedge clk) begin
        bit rdy;
        if (!rst) begin
            mq.delete();
            ml.delete();
            m_ov   = 1'b0;
            m_last = 1'b0;
            m_word = '0;
            m_ovf  = 1'b0;
        end else if (ce) begin
            rdy = m_rdy();
            if (!m_ov || bus.s_out_rdy) begin
                if (mq.size() > 0) begin
                    m_ov   = 1'b1;
                    m_word = mq.pop_front();
                    m_last = ml.pop_front();
                end else begin
                    m_ov   = 1'b0;
                    m_last = 1'b0;
                end
            end
            if (bus.p_in_v && rdy) begin
                for (int i = 0; i < PE_NUM; i++) begin
                    mq.push_back(bus.p_in[i*WW +: WW]);
                    ml.push_back(i == PE_NUM - 1);
                end
            end else if (bus.p_in_v && OVF_EN) begin
                m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("p_in_rdy", bus.p_in_rdy, m_rdy());
            chk("s_out_v", bus.s_out_v, m_ov);
            if (m_ov) begin
                chk("s_out", bus.s_out, m_word);
                chk("s_out_last", bus.s_out_last, m_last);
            end
            chk("overflow", overflow, m_ovf);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [PE_NUM*WW-1:0] rnd_frame();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int ce_hold;
        bus.p_in_v    = 1'b0;
        bus.p_in      = '0;
        bus.s_out_rdy = 1'b0;
        rst = 1'b0;
        ce  = 1'b1;

        // Reset for two cycles
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_s_out_v", bus.s_out_v, 0);
        chk("rst_s_out", bus.s_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_p_in_rdy", bus.p_in_rdy, 1);

        // Single known frame
        rst = 1'b1;
        bus.s_out_rdy = 1'b1;
        bus.p_in_v    = 1'b1;
        bus.p_in      = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk);
        bus.p_in_v = 1'b0;
        chk("single_lat0", bus.s_out_v, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("single_v", bus.s_out_v, 1);
            chk("single_word", bus.s_out, 64'(k));
            chk("single_last", bus.s_out_last, (k == 4) ? 1 : 0);
        end
        @(negedge clk);
        chk("single_done", bus.s_out_v, 0);

        // Back-to-back frames, one every four cycles
        for (int f = 0; f < 2; f++) begin
            bus.p_in_v = 1'b1;
            bus.p_in   = rnd_frame();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                bus.p_in_v = 1'b0;
                chk("b2b_rdy", bus.p_in_rdy, 1);
                if (f > 0 || c > 0) chk("b2b_contig", bus.s_out_v, 1);
            end
        end
        @(negedge clk);
        chk("b2b_tail_v", bus.s_out_v, 1);
        chk("b2b_tail_last", bus.s_out_last, 1);
        @(negedge clk);
        chk("b2b_idle", bus.s_out_v, 0);

        // Stalled sink, three frames offered
        bus.s_out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.p_in_v = 1'b1;
            bus.p_in   = rnd_frame();
            @(negedge clk);
        end
        chk("full_rdy", bus.p_in_rdy, 0);
        chk("full_ovf", overflow, OVF_EN);
        bus.p_in_v = 1'b0;
        repeat (7) @(negedge clk);
        chk("full_hold_rdy", bus.p_in_rdy, 0);
        bus.s_out_rdy = 1'b1;
        repeat (12) @(negedge clk);
        chk("drained", bus.s_out_v, 0);

        // Randomized traffic: toggling ready, ce bursts and rare resets
        ce_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (ce_hold > 0) begin
                ce_hold--;
            end else begin
                ce = ($urandom_range(0, 5) != 0);
                ce_hold = $urandom_range(0, 4);
            end
            if (n < 1000) bus.s_out_rdy = n[0];
            else          bus.s_out_rdy = ($urandom_range(0, 2) != 0);
            bus.p_in_v = $urandom_range(0, 1) == 1;
            bus.p_in   = rnd_frame();
            rst = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end

        // Reset in the middle of a frame
        rst = 1'b1;
        ce  = 1'b1;
        bus.p_in_v    = 1'b0;
        bus.s_out_rdy = 1'b1;
        repeat (12) @(negedge clk);
        bus.p_in_v = 1'b1;
        bus.p_in   = rnd_frame();
        @(negedge clk);
        bus.p_in_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_word2_v", bus.s_out_v, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_v", bus.s_out_v, 0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_tail", bus.s_out_v, 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
